wptr_full_lvl: RTL and testbench

Write-side pointer and status block for the dual-clock FIFO, parametrised successor of the basic write-pointer/full generator. Runs entirely in the write clock domain. Maintains the binary write address and the Gray-coded write pointer for the read-side synchroniser, and compares against the already-synchronised Gray read pointer. Beyond full detection, it provides:

- a registered fill level;
- a programmable almost-full flag;
- a write-accept strobe;
- a sticky overflow error with software clear.

---
 rtl/wptr_full_lvl.sv | 125 ++++++++++++
 tb/tb_wptr_full_lvl.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wptr_full_lvl.sv
`default_nettype none
// ============================================================================
// Module   : wptr_full_lvl
// Purpose  : Write-side pointer and status generator for a dual-clock FIFO.
//            Lives entirely in the write clock domain. It keeps the binary
//            write address and the Gray write pointer that is handed to the
//            read-side synchroniser. It compares against the Gray read
//            pointer that has already been synchronised into this domain, and
//            from that produces full, almost-full, fill level, a write-accept
//            strobe and a sticky overflow flag.
// Ports    : wclk_i           write clock, rising edge
//            wrst_i           asynchronous active-high reset
//            winc_i           write request
//            wq2_rptr_i       synchronised Gray read pointer  [ADDR_SIZE:0]
//            afull_thresh_i   almost-full threshold in words  [ADDR_SIZE:0]
//            wovf_clr_i       clears the sticky overflow flag
//            wack_o           write accepted this cycle (memory write enable)
//            waddr_o          memory write address            [ADDR_SIZE-1:0]
//            wptr_o           Gray write pointer              [ADDR_SIZE:0]
//            wfull_o          FIFO full
//            walmost_full_o   level >= afull_thresh_i
//            wlevel_o         words held, 0..2**ADDR_SIZE     [ADDR_SIZE:0]
//            woverflow_o      sticky: write attempted while full
// Revision : 1.0 - initial release
// ============================================================================
module wptr_full_lvl #(
  parameter int ADDR_SIZE = 12
) (
  input  logic                 wclk_i,
  input  logic                 wrst_i,
  input  logic                 winc_i,
  input  logic [ADDR_SIZE:0]   wq2_rptr_i,
  input  logic [ADDR_SIZE:0]   afull_thresh_i,
  input  logic                 wovf_clr_i,
  output logic                 wack_o,
  output logic [ADDR_SIZE-1:0] waddr_o,
  output logic [ADDR_SIZE:0]   wptr_o,
  output logic                 wfull_o,
  output logic                 walmost_full_o,
  output logic [ADDR_SIZE:0]   wlevel_o,
  output logic                 woverflow_o
);

  // Pointer width: one extra bit beyond the address distinguishes full
  // from empty when the address bits are equal.
  localparam int PW = ADDR_SIZE + 1;

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  logic [PW-1:0] wbin_q,  wbin_d;
  logic [PW-1:0] wptr_q,  wptr_d;
  logic [PW-1:0] wlvl_q,  wlvl_d;
  logic          wfull_q, wfull_d;
  logic          wafull_q, wafull_d;
  logic          wovf_q,  wovf_d;

  // --------------------------------------------------------------------------
  // Combinational helpers
  // --------------------------------------------------------------------------
  logic          wack;
  logic [PW-1:0] rbin;
  logic [PW-1:0] rptr_full_pat;

  // A write is taken only when the FIFO is not already full. The refused
  // write leaves every pointer untouched and only feeds the overflow flag.
  assign wack = winc_i & ~wfull_q;

  // Gray-to-binary of the synchronised read pointer: each binary bit is the
  // XOR of all Gray bits from the MSB down to that position.
  assign rbin[PW-1] = wq2_rptr_i[PW-1];
  for (genvar gi = PW - 2; gi >= 0; gi--) begin : g_rgray2bin
    assign rbin[gi] = rbin[gi+1] ^ wq2_rptr_i[gi];
  end

  // The write pointer is exactly one lap ahead of the read pointer when the
  // two top Gray bits differ and the remaining bits are equal.
  assign rptr_full_pat = {~wq2_rptr_i[PW-1:PW-2], wq2_rptr_i[PW-3:0]};

  always_comb begin
    wbin_d   = wbin_q + PW'(wack);
    wptr_d   = (wbin_d >> 1) ^ wbin_d;
    // Modular subtraction keeps the level correct across pointer wrap.
    wlvl_d   = wbin_d - rbin;
    wfull_d  = (wptr_d == rptr_full_pat);
    wafull_d = (wlvl_d >= afull_thresh_i);
    // Set has priority over clear so a write refused in the same cycle as
    // a software clear is never lost.
    wovf_d   = (winc_i & wfull_q) | (wovf_q & ~wovf_clr_i);
  end

  // --------------------------------------------------------------------------
  // Sequential state
  // --------------------------------------------------------------------------
  always_ff @(posedge wclk_i or posedge wrst_i) begin
    if (wrst_i) begin
      wbin_q   <= '0;
      wptr_q   <= '0;
      wlvl_q   <= '0;
      wfull_q  <= 1'b0;
      wafull_q <= 1'b0;
      wovf_q   <= 1'b0;
    end else begin
      wbin_q   <= wbin_d;
      wptr_q   <= wptr_d;
      wlvl_q   <= wlvl_d;
      wfull_q  <= wfull_d;
      wafull_q <= wafull_d;
      wovf_q   <= wovf_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign wack_o         = wack;
  assign waddr_o        = wbin_q[ADDR_SIZE-1:0];
  assign wptr_o         = wptr_q;
  assign wfull_o        = wfull_q;
  assign walmost_full_o = wafull_q;
  assign wlevel_o       = wlvl_q;
  assign woverflow_o    = wovf_q;

endmodule
`default_nettype wire

// File: tb/tb_wptr_full_lvl.sv
`default_nettype none
// ============================================================================
// Module   : tb_wptr_full_lvl
// Purpose  : Self-checking bench for wptr_full_lvl. Drives a DEPTH-8 and a
//            DEPTH-4096 instance from one clock. A behavioural model tracks
//            integer write/read word counts and derives every output from
//            them. Directed scenarios pin the model with literal values, and
//            a randomised phase exercises thresholds, reads and overflow.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wptr_full_lvl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Stimulus, one slot per instance: [0] ADDR_SIZE=3, [1] ADDR_SIZE=12.
  // s_rd is the integer count of words the read side has consumed.
  int s_winc[2], s_rd[2], s_thr[2], s_clr[2];

  // Model state: accepted-write count plus registered status.
  int m_wr[2], m_lvl[2];
  bit m_full[2], m_af[2], m_ovf[2];

  int  n_chk  = 0;
  int  n_fail = 0;
  bit  chk_en = 1'b0;

  function automatic int gray(int b);
    return b ^ (b >> 1);
  endfunction

  function automatic int asz(int k);
    return (k == 0) ? 3 : 12;
  endfunction

  // ---------------- DUT, ADDR_SIZE = 3 ----------------
  logic        winc3, clr3, wack3, wfull3, waf3, wovf3;
  logic [3:0]  wq2_3, thr3, wptr3, wlvl3;
  logic [2:0]  waddr3;
  assign winc3 = s_winc[0][0];
  assign clr3  = s_clr[0][0];
  assign wq2_3 = 4'(gray(s_rd[0] & 15));
  assign thr3  = 4'(s_thr[0]);

  wptr_full_lvl #(.ADDR_SIZE(3)) u_dut3 (
    .wclk_i(clk), .wrst_i(rst), .winc_i(winc3), .wq2_rptr_i(wq2_3),
    .afull_thresh_i(thr3), .wovf_clr_i(clr3), .wack_o(wack3),
    .waddr_o(waddr3), .wptr_o(wptr3), .wfull_o(wfull3),
    .walmost_full_o(waf3), .wlevel_o(wlvl3), .woverflow_o(wovf3)
  );

  // ---------------- DUT, ADDR_SIZE = 12 ----------------
  logic        winc12, clr12, wack12, wfull12, waf12, wovf12;
  logic [12:0] wq2_12, thr12, wptr12, wlvl12;
  logic [11:0] waddr12;
  assign winc12 = s_winc[1][0];
  assign clr12  = s_clr[1][0];
  assign wq2_12 = 13'(gray(s_rd[1] & 8191));
  assign thr12  = 13'(s_thr[1]);

  wptr_full_lvl #(.ADDR_SIZE(12)) u_dut12 (
    .wclk_i(clk), .wrst_i(rst), .winc_i(winc12), .wq2_rptr_i(wq2_12),
    .afull_thresh_i(thr12), .wovf_clr_i(clr12), .wack_o(wack12),
    .waddr_o(waddr12), .wptr_o(wptr12), .wfull_o(wfull12),
    .walmost_full_o(waf12), .wlevel_o(wlvl12), .woverflow_o(wovf12)
  );

  // ---------------- Checking helpers ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: level is simply words written minus words read.
  always @(posedge clk or posedge rst) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_wr[k] = 0; m_lvl[k] = 0; m_full[k] = 0; m_af[k] = 0; m_ovf[k] = 0;
      end else begin
        int d;
        bit acc;
        d         = 1 << asz(k);
        acc       = (s_winc[k] != 0) && !m_full[k];
        m_ovf[k]  = ((s_winc[k] != 0) && m_full[k]) || (m_ovf[k] && (s_clr[k] == 0));
        m_wr[k]   = m_wr[k] + (acc ? 1 : 0);
        m_lvl[k]  = m_wr[k] - s_rd[k];
        m_full[k] = (m_lvl[k] == d);
        m_af[k]   = (m_lvl[k] >= s_thr[k]);
      end
    end
  end

  task automatic cmp(input int k, input string t, input logic ack,
                     input logic [31:0] addr, input logic [31:0] ptr,
                     input logic full, input logic af,
                     input logic [31:0] lvl, input logic ovf);
    int d;
    d = 1 << asz(k);
    chk({t, " wack"},   {31'd0, ack},  {31'd0, (s_winc[k] != 0) && !m_full[k]});
    chk({t, " waddr"},  addr, m_wr[k] % d);
    chk({t, " wptr"},   ptr,  gray(m_wr[k] % (2 * d)));
    chk({t, " wfull"},  {31'd0, full}, {31'd0, m_full[k]});
    chk({t, " wafull"}, {31'd0, af},   {31'd0, m_af[k]});
    chk({t, " wlevel"}, lvl,  m_lvl[k]);
    chk({t, " wovf"},   {31'd0, ovf},  {31'd0, m_ovf[k]});
  endtask

  // Compare process: every cycle, mid-low-phase, both instances.
  always @(negedge clk) begin
    #1;
    if (chk_en) begin
      cmp(0, "d3",  wack3,  32'(waddr3),  32'(wptr3),  wfull3,  waf3,  32'(wlvl3),  wovf3);
      cmp(1, "d12", wack12, 32'(waddr12), 32'(wptr12), wfull12, waf12, 32'(wlvl12), wovf12);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      s_winc[k] = 0; s_rd[k] = 0; s_clr[k] = 0;
    end
    tick();
    rst = 1'b0;
  endtask

  // ---------------- Stimulus ----------------
  initial begin : stim
    int tbl[8];
    int wcnt;
    tbl = '{1, 3, 2, 6, 7, 5, 4, 12};
    s_thr[0] = 9; s_thr[1] = 4097;
    for (int k = 0; k < 2; k++) begin
      s_winc[k] = 0; s_rd[k] = 0; s_clr[k] = 0;
    end
    chk_en = 1'b1;
    tick();
    chk("reset wptr", 32'(wptr3), 0);
    chk("reset wlevel", 32'(wlvl3), 0);
    chk("reset wfull", 32'(wfull3), 0);
    rst = 1'b0;

    // Fill to full with an unreachable threshold.
    s_winc[0] = 1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("s1 wptr", 32'(wptr3), tbl[i]);
      chk("s1 wlevel", 32'(wlvl3), i + 1);
      chk("s1 wfull", 32'(wfull3), (i == 7) ? 1 : 0);
      chk("s1 wafull", 32'(waf3), 0);
    end
    chk("s1 wack refused", 32'(wack3), 0);

    // Overflow and its clear priority.
    tick();
    chk("s2 wptr", 32'(wptr3), 12);
    chk("s2 wlevel", 32'(wlvl3), 8);
    chk("s2 wovf set", 32'(wovf3), 1);
    s_clr[0] = 1;
    tick();
    chk("s2 wovf set wins", 32'(wovf3), 1);
    s_winc[0] = 0;
    tick();
    chk("s2 wovf cleared", 32'(wovf3), 0);
    s_clr[0] = 0;

    // Almost-full at threshold 6, then drain while full.
    do_reset();
    s_thr[0] = 6;
    s_winc[0] = 1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      chk("s3 wafull", 32'(waf3), (i == 6) ? 1 : 0);
      chk("s3 wfull", 32'(wfull3), 0);
    end
    tick(); tick();
    chk("s4 full before drain", 32'(wfull3), 1);
    s_winc[0] = 0;
    s_rd[0] = 3;
    tick();
    chk("s4 wlevel", 32'(wlvl3), 5);
    chk("s4 wfull", 32'(wfull3), 0);
    chk("s4 wafull", 32'(waf3), 0);

    // Wrap-around with the reader trailing four words behind.
    wcnt = 8;
    for (int i = 0; i < 20; i++) begin
      s_rd[0] = wcnt + 1 - 4;
      s_winc[0] = 1;
      tick();
      wcnt++;
      chk("s5 wlevel", 32'(wlvl3), 4);
      chk("s5 wfull", 32'(wfull3), 0);
    end
    chk("s5 wptr wrapped", 32'(wptr3), gray(28 % 16));
    s_winc[0] = 0;

    // Asynchronous reset mid-burst, no clock edge required.
    do_reset();
    s_thr[0] = 9;
    s_winc[0] = 1;
    repeat (5) tick();
    chk("s6 wlevel before rst", 32'(wlvl3), 5);
    #2;
    rst = 1'b1;
    #1;
    chk("s6 async wptr", 32'(wptr3), 0);
    chk("s6 async waddr", 32'(waddr3), 0);
    chk("s6 async wlevel", 32'(wlvl3), 0);
    chk("s6 async wfull", 32'(wfull3), 0);
    chk("s6 async wafull", 32'(waf3), 0);
    chk("s6 async wovf", 32'(wovf3), 0);
    chk("s6 async wack", 32'(wack3), 1);

    // Randomised phase on the small instance.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      int avail;
      s_winc[0] = ($urandom_range(0, 3) != 0) ? 1 : 0;
      s_clr[0]  = ($urandom_range(0, 7) == 0) ? 1 : 0;
      if ($urandom_range(0, 31) == 0) s_thr[0] = $urandom_range(0, 10);
      avail = m_wr[0] - s_rd[0];
      if (avail > 2) avail = 2;
      s_rd[0] = s_rd[0] + $urandom_range(0, avail);
      tick();
    end
    s_winc[0] = 0;
    s_clr[0] = 0;

    // Large instance: fill all 4096 words.
    do_reset();
    s_winc[1] = 1;
    for (int i = 1; i <= 4096; i++) begin
      tick();
      if (i == 4095) chk("s6b wfull early", 32'(wfull12), 0);
    end
    chk("s6b wfull", 32'(wfull12), 1);
    chk("s6b wlevel", 32'(wlvl12), 4096);
    chk("s6b wptr", 32'(wptr12), 6144);
    chk("s6b wack refused", 32'(wack12), 0);
    tick();
    chk("s6b wovf", 32'(wovf12), 1);
    s_winc[1] = 0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
